uart_ctrl: RTL and testbench

- Bus-facing controller that sequences the 8N1 `uart` core: buffers CPU writes in a TX FIFO and launches bytes with the core's `tx_wr`/`tx_busy` handshake.
- Drains received bytes from the core's `rx_avail`/`rx_ack` handshake into an RX FIFO.
- Presents a 3-register memory-mapped interface plus a level interrupt to the femtoRV peripheral bus.
- Sits between the SoC bus decoder and one `uart` instance.

---
 rtl/uart_ctrl_pkg.sv | 31 +++
 rtl/sync_fifo.sv | 69 ++++++
 rtl/uart_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_uart_ctrl.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_ctrl_pkg.sv
// Shared definitions for the UART bus controller.
// Holds the register indices, the STATUS/CTRL bit positions and the TX sequencer state
// encoding. Both the top level and the testbench refer to these names.
package uart_ctrl_pkg;

  // Register indices on the 2-bit bus address.
  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;

  // STATUS bit positions.
  localparam int unsigned ST_RX_NONEMPTY = 0;
  localparam int unsigned ST_TX_EMPTY    = 1;
  localparam int unsigned ST_TX_FULL     = 2;
  localparam int unsigned ST_RX_ERR      = 3;
  localparam int unsigned ST_RX_OVERRUN  = 4;
  localparam int unsigned ST_TX_OVERFLOW = 5;
  localparam int unsigned ST_TX_IDLE     = 6;

  // CTRL bit positions.
  localparam int unsigned CTRL_RX_IRQ_EN = 0;
  localparam int unsigned CTRL_TX_IRQ_EN = 1;

  // TX sequencer states.
  typedef enum logic [1:0] {
    TxIdle     = 2'd0,
    TxWaitBusy = 2'd1,
    TxWaitDone = 2'd2
  } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with show-ahead output.
// The head entry is visible on dout combinationally whenever the FIFO is not empty.
// A push and a pop in the same cycle are both performed; when the FIFO is full, a push
// is still accepted if a pop happens in that same cycle, because the pop frees the slot.
// A pop on an empty FIFO does nothing.
// Ports:
//   clk    - clock
//   reset  - synchronous, active-high; empties the FIFO
//   push   - write din into the tail
//   pop    - discard the head entry
//   din    - write data
//   dout   - head entry (show-ahead)
//   empty  - no entries stored
//   full   - 2**AW entries stored
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AW    = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int unsigned Depth = 1 << AW;
  localparam logic [AW:0] DepthCnt = (AW + 1)'(Depth);

  logic [WIDTH-1:0] mem_q [Depth];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [AW:0]      cnt_q;
  logic             do_push, do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == DepthCnt);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem_q[rptr_q];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wptr_q] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) begin
        wptr_q <= wptr_q + 1'b1;
      end
      if (do_pop) begin
        rptr_q <= rptr_q + 1'b1;
      end
      unique case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_ctrl.sv
// Bus-facing controller for an 8N1 UART core.
// CPU writes are queued in a TX FIFO and launched one at a time using the core's
// tx_wr/tx_busy handshake; received bytes are drained from the core's rx_avail/rx_ack
// handshake into an RX FIFO. Three registers (DATA, STATUS, CTRL) plus a level interrupt
// are exposed on the peripheral bus.
// Ports:
//   clk, reset                      - clock, synchronous active-high reset
//   bus_sel/we/addr/wdata           - single-cycle register access strobe and payload
//   bus_rdata                       - registered read data, valid the cycle after a read
//   irq                             - registered level interrupt
//   u_tx_data/u_tx_wr/u_tx_busy     - transmit handshake with the core
//   u_rx_data/u_rx_avail/u_rx_error - receive status from the core
//   u_rx_ack                        - one-cycle acknowledge clearing the core's rx flags
module uart_ctrl
  import uart_ctrl_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned FIFO_AW    = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       bus_sel,
  input  logic       bus_we,
  input  logic [1:0] bus_addr,
  input  logic [7:0] bus_wdata,
  output logic [7:0] bus_rdata,
  output logic       irq,
  output logic [7:0] u_tx_data,
  output logic       u_tx_wr,
  input  logic       u_tx_busy,
  input  logic [7:0] u_rx_data,
  input  logic       u_rx_avail,
  input  logic       u_rx_error,
  output logic       u_rx_ack
);

  if (FIFO_DEPTH != (1 << FIFO_AW)) begin : g_depth_check
    $error("FIFO_DEPTH must equal 2**FIFO_AW");
  end

  tx_state_e  tx_state_q;
  logic       u_tx_wr_q;
  logic [7:0] u_tx_data_q;
  logic [7:0] bus_rdata_q, rdata_d;
  logic       irq_q, irq_d;
  logic [1:0] ctrl_q;
  logic       u_rx_ack_q, ack_pend_q;
  // Sticky flags: [0] rx_err, [1] rx_overrun, [2] tx_overflow.
  logic [2:0] sticky_q, sticky_d, sticky_set, sticky_clr;

  logic       bus_rd, bus_wr;
  logic       tx_push, tx_pop, tx_empty, tx_full;
  logic [7:0] tx_head;
  logic       rx_push, rx_pop, rx_empty, rx_full, rx_start;
  logic [7:0] rx_head;
  logic       tx_idle;
  logic [7:0] status;

  assign bus_rd = bus_sel & ~bus_we;
  assign bus_wr = bus_sel & bus_we;

  assign tx_push = bus_wr & (bus_addr == REG_DATA);
  // Launch decision is made in TxIdle; the head is popped now and the strobe is
  // registered, so the core sees u_tx_wr one cycle later.
  assign tx_pop  = (tx_state_q == TxIdle) & ~tx_empty & ~u_tx_busy;

  // Only the first cycle of an rx_avail/rx_error episode is taken; ack_pend masks the
  // cycles until the core drops both flags.
  assign rx_start = (u_rx_avail | u_rx_error) & ~ack_pend_q;
  assign rx_push  = rx_start & u_rx_avail;
  assign rx_pop   = bus_rd & (bus_addr == REG_DATA) & ~rx_empty;

  sync_fifo #(
    .WIDTH(8),
    .AW   (FIFO_AW)
  ) u_tx_fifo (
    .clk  (clk),
    .reset(reset),
    .push (tx_push),
    .pop  (tx_pop),
    .din  (bus_wdata),
    .dout (tx_head),
    .empty(tx_empty),
    .full (tx_full)
  );

  sync_fifo #(
    .WIDTH(8),
    .AW   (FIFO_AW)
  ) u_rx_fifo (
    .clk  (clk),
    .reset(reset),
    .push (rx_push),
    .pop  (rx_pop),
    .din  (u_rx_data),
    .dout (rx_head),
    .empty(rx_empty),
    .full (rx_full)
  );

  assign tx_idle = tx_empty & (tx_state_q == TxIdle) & ~u_tx_busy;

  always_comb begin
    status                 = '0;
    status[ST_RX_NONEMPTY] = ~rx_empty;
    status[ST_TX_EMPTY]    = tx_empty;
    status[ST_TX_FULL]     = tx_full;
    status[ST_RX_ERR]      = sticky_q[0];
    status[ST_RX_OVERRUN]  = sticky_q[1];
    status[ST_TX_OVERFLOW] = sticky_q[2];
    status[ST_TX_IDLE]     = tx_idle;
  end

  always_comb begin
    // A full FIFO still accepts a push when the same cycle pops, so only count a drop
    // when no slot is freed.
    sticky_set    = '0;
    sticky_set[0] = rx_start & u_rx_error;
    sticky_set[1] = rx_push & rx_full & ~rx_pop;
    sticky_set[2] = tx_push & tx_full & ~tx_pop;

    sticky_clr = '0;
    if (bus_wr && bus_addr == REG_STATUS) begin
      sticky_clr = bus_wdata[ST_TX_OVERFLOW:ST_RX_ERR];
    end
    // A new event in the same cycle as a clear wins.
    sticky_d = (sticky_q & ~sticky_clr) | sticky_set;
  end

  always_comb begin
    rdata_d = bus_rdata_q;
    if (bus_rd) begin
      unique case (bus_addr)
        REG_DATA:   rdata_d = rx_empty ? 8'h00 : rx_head;
        REG_STATUS: rdata_d = status;
        REG_CTRL:   rdata_d = {6'b0, ctrl_q};
        default:    rdata_d = 8'h00;
      endcase
    end
  end

  assign irq_d = (ctrl_q[CTRL_RX_IRQ_EN] & ~rx_empty) | (ctrl_q[CTRL_TX_IRQ_EN] & tx_empty) |
                 sticky_q[0] | sticky_q[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      bus_rdata_q <= '0;
      irq_q       <= 1'b0;
      ctrl_q      <= '0;
      sticky_q    <= '0;
      u_rx_ack_q  <= 1'b0;
      ack_pend_q  <= 1'b0;
    end else begin
      bus_rdata_q <= rdata_d;
      irq_q       <= irq_d;
      sticky_q    <= sticky_d;
      u_rx_ack_q  <= rx_start;
      if (bus_wr && bus_addr == REG_CTRL) begin
        ctrl_q <= bus_wdata[1:0];
      end
      if (rx_start) begin
        ack_pend_q <= 1'b1;
      end else if (!u_rx_avail && !u_rx_error) begin
        ack_pend_q <= 1'b0;
      end
    end
  end

  // TX sequencer: launch, wait for the core to go busy, wait for it to finish.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state_q  <= TxIdle;
      u_tx_wr_q   <= 1'b0;
      u_tx_data_q <= '0;
    end else begin
      u_tx_wr_q <= 1'b0;
      unique case (tx_state_q)
        TxIdle: begin
          if (tx_pop) begin
            u_tx_data_q <= tx_head;
            u_tx_wr_q   <= 1'b1;
            tx_state_q  <= TxWaitBusy;
          end
        end
        TxWaitBusy: begin
          if (u_tx_busy) begin
            tx_state_q <= TxWaitDone;
          end
        end
        TxWaitDone: begin
          if (!u_tx_busy) begin
            tx_state_q <= TxIdle;
          end
        end
        default: tx_state_q <= TxIdle;
      endcase
    end
  end

  assign bus_rdata = bus_rdata_q;
  assign irq       = irq_q;
  assign u_tx_data = u_tx_data_q;
  assign u_tx_wr   = u_tx_wr_q;
  assign u_rx_ack  = u_rx_ack_q;

endmodule

// File: tb/tb_uart_ctrl.sv
// Testbench for uart_ctrl: behavioural UART core models on both sides, a queue-based
// reference model that predicts every registered output each cycle, and a monitor that
// pops the predictions and compares them with the DUT.
module tb_uart_ctrl;

  localparam int unsigned Depth = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       bus_sel, bus_we;
  logic [1:0] bus_addr;
  logic [7:0] bus_wdata, bus_rdata;
  logic       irq;
  logic [7:0] u_tx_data;
  logic       u_tx_wr, u_tx_busy;
  logic [7:0] u_rx_data;
  logic       u_rx_avail, u_rx_error, u_rx_ack;

  always #5 clk = ~clk;

  uart_ctrl #(
    .FIFO_DEPTH(Depth),
    .FIFO_AW   (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus_sel   (bus_sel),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .irq       (irq),
    .u_tx_data (u_tx_data),
    .u_tx_wr   (u_tx_wr),
    .u_tx_busy (u_tx_busy),
    .u_rx_data (u_rx_data),
    .u_rx_avail(u_rx_avail),
    .u_rx_error(u_rx_error),
    .u_rx_ack  (u_rx_ack)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic       irq;
    logic [7:0] rdata;
    logic       wr;
    logic [7:0] tdata;
    logic       ack;
  } exp_t;

  exp_t exp_q[$];

  task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] expv);
    checks++;
    if (got !== expv) begin
      failures++;
      $display("FAIL %s at %0t: got %02h expected %02h", nm, $time, got, expv);
    end
  endtask

  // ---------------- TX core model ----------------
  bit force_busy = 1'b0;
  int tx_len_min = 2;
  int tx_len_max = 6;

  initial begin
    int rem;
    rem       = 0;
    u_tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (u_tx_wr) rem = int'($urandom_range(tx_len_max, tx_len_min));
      else if (rem > 0) rem--;
      u_tx_busy = force_busy || (rem > 0);
    end
  end

  // ---------------- RX core model ----------------
  typedef struct {
    bit         avail;
    bit         err;
    logic [7:0] data;
    int         hold;
  } rx_item_t;

  rx_item_t rx_send_q[$];

  initial begin
    rx_item_t it;
    bit got;
    u_rx_avail = 1'b0;
    u_rx_error = 1'b0;
    u_rx_data  = 8'h00;
    forever begin
      @(negedge clk);
      if (rx_send_q.size() > 0) begin
        it         = rx_send_q.pop_front();
        u_rx_avail = it.avail;
        u_rx_error = it.err;
        u_rx_data  = it.data;
        got        = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
          @(negedge clk);
          if (u_rx_ack) got = 1'b1;
        end
        checks++;
        if (!got) begin
          failures++;
          $display("FAIL rx_ack_timeout at %0t: got no ack expected ack within 20 cycles",
                   $time);
        end
        for (int i = 0; i < it.hold; i++) @(negedge clk);
        u_rx_avail = 1'b0;
        u_rx_error = 1'b0;
      end
    end
  end

  // ---------------- Reference model ----------------
  // Works directly from the register-map rules with byte queues for the FIFOs.
  logic [7:0] m_txq[$];
  logic [7:0] m_rxq[$];
  bit         m_err, m_ovr, m_ovf, m_pend;
  bit   [1:0] m_ctrl;
  int         m_frame;  // 0 free, 1 launched awaiting busy, 2 core transmitting
  logic [7:0] m_rdata, m_tdata;

  initial begin
    exp_t e;
    bit rx_ne, tx_e, tx_f, idle, rd, wr, launch, start;
    logic [7:0] st;
    forever begin
      @(posedge clk);
      e = '{irq: 1'b0, rdata: 8'h00, wr: 1'b0, tdata: 8'h00, ack: 1'b0};
      if (reset) begin
        m_txq.delete();
        m_rxq.delete();
        {m_err, m_ovr, m_ovf, m_pend} = '0;
        m_ctrl  = '0;
        m_frame = 0;
        m_rdata = 8'h00;
        m_tdata = 8'h00;
      end else begin
        rx_ne = (m_rxq.size() != 0);
        tx_e  = (m_txq.size() == 0);
        tx_f  = (m_txq.size() == Depth);
        idle  = tx_e && (m_frame == 0) && !u_tx_busy;
        rd    = bus_sel && !bus_we;
        wr    = bus_sel && bus_we;
        e.irq = (m_ctrl[0] && rx_ne) || (m_ctrl[1] && tx_e) || m_err || m_ovr;
        st    = {1'b0, idle, m_ovf, m_ovr, m_err, tx_f, tx_e, rx_ne};
        if (rd) begin
          case (bus_addr)
            2'd0:    m_rdata = rx_ne ? m_rxq[0] : 8'h00;
            2'd1:    m_rdata = st;
            2'd2:    m_rdata = {6'b0, m_ctrl};
            default: m_rdata = 8'h00;
          endcase
        end
        // TX: launch first, then accept the write into whatever space remains.
        launch = (m_frame == 0) && !tx_e && !u_tx_busy;
        e.wr   = launch;
        if (launch) m_tdata = m_txq.pop_front();
        if (wr && bus_addr == 2'd0) begin
          if (m_txq.size() < Depth) m_txq.push_back(bus_wdata);
          else m_ovf = 1'b1;
        end
        if (m_frame == 1 && u_tx_busy) m_frame = 2;
        else if (m_frame == 2 && !u_tx_busy) m_frame = 0;
        if (launch) m_frame = 1;
        // RX: the read pop happens before the incoming byte is stored.
        if (wr && bus_addr == 2'd1) begin
          if (bus_wdata[3]) m_err = 1'b0;
          if (bus_wdata[4]) m_ovr = 1'b0;
          if (bus_wdata[5]) m_ovf = 1'b0;
        end
        if (launch == 1'b0 && wr && bus_addr == 2'd0 && tx_f) m_ovf = 1'b1;
        if (rd && bus_addr == 2'd0 && rx_ne) void'(m_rxq.pop_front());
        start = (u_rx_avail || u_rx_error) && !m_pend;
        e.ack = start;
        if (start && u_rx_avail) begin
          if (m_rxq.size() < Depth) m_rxq.push_back(u_rx_data);
          else m_ovr = 1'b1;
        end
        if (start && u_rx_error) m_err = 1'b1;
        if (start) m_pend = 1'b1;
        else if (!u_rx_avail && !u_rx_error) m_pend = 1'b0;
        if (wr && bus_addr == 2'd2) m_ctrl = bus_wdata[1:0];
      end
      e.rdata = m_rdata;
      e.tdata = m_tdata;
      exp_q.push_back(e);
    end
  end

  // ---------------- Monitor ----------------
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("irq", {7'b0, irq}, {7'b0, e.irq});
        chk("bus_rdata", bus_rdata, e.rdata);
        chk("u_tx_wr", {7'b0, u_tx_wr}, {7'b0, e.wr});
        chk("u_tx_data", u_tx_data, e.tdata);
        chk("u_rx_ack", {7'b0, u_rx_ack}, {7'b0, e.ack});
      end
    end
  end

  // ---------------- Stimulus ----------------
  task automatic bus_op(input bit we, input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    bus_sel   = 1'b1;
    bus_we    = we;
    bus_addr  = a;
    bus_wdata = d;
    @(negedge clk);
    bus_sel   = 1'b0;
    bus_we    = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rx_send(input bit avail, input bit err, input logic [7:0] d, input int hold);
    rx_item_t it;
    it.avail = avail;
    it.err   = err;
    it.data  = d;
    it.hold  = hold;
    rx_send_q.push_back(it);
  endtask

  task automatic wait_rx_drained();
    int n;
    n = 0;
    while ((rx_send_q.size() != 0 || u_rx_avail || u_rx_error) && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 300) begin
      failures++;
      $display("FAIL rx_drain_timeout at %0t: got pending items expected none", $time);
    end
  endtask

  initial begin
    int r;
    reset     = 1'b1;
    bus_sel   = 1'b0;
    bus_we    = 1'b0;
    bus_addr  = 2'd0;
    bus_wdata = 8'h00;
    idle_cycles(3);
    reset = 1'b0;
    idle_cycles(2);
    for (int a = 0; a < 4; a++) bus_op(1'b0, 2'(a), 8'h00);

    // Two bytes through the transmitter.
    bus_op(1'b1, 2'd0, 8'h41);
    bus_op(1'b1, 2'd0, 8'h42);
    idle_cycles(30);
    bus_op(1'b0, 2'd1, 8'h00);

    // Overflow with the core held busy.
    bus_op(1'b1, 2'd0, 8'h01);
    idle_cycles(2);
    force_busy = 1'b1;
    for (int i = 2; i <= 6; i++) bus_op(1'b1, 2'd0, 8'(i));
    bus_op(1'b0, 2'd1, 8'h00);
    bus_op(1'b1, 2'd1, 8'h20);
    bus_op(1'b0, 2'd1, 8'h00);
    force_busy = 1'b0;
    idle_cycles(60);

    // Single byte held for three cycles.
    rx_send(1'b1, 1'b0, 8'h5A, 2);
    wait_rx_drained();
    idle_cycles(2);
    bus_op(1'b0, 2'd1, 8'h00);
    bus_op(1'b0, 2'd0, 8'h00);
    bus_op(1'b0, 2'd1, 8'h00);

    // RX overrun.
    for (int i = 1; i <= 5; i++) rx_send(1'b1, 1'b0, 8'(8'hA0 + i), 0);
    wait_rx_drained();
    idle_cycles(2);
    bus_op(1'b0, 2'd1, 8'h00);
    for (int i = 0; i < 5; i++) bus_op(1'b0, 2'd0, 8'h00);
    bus_op(1'b1, 2'd1, 8'h10);

    // Framing error alone.
    rx_send(1'b0, 1'b1, 8'h00, 0);
    wait_rx_drained();
    idle_cycles(2);
    bus_op(1'b0, 2'd1, 8'h00);
    bus_op(1'b1, 2'd1, 8'h08);
    idle_cycles(2);

    // Reset while a frame is in flight with bytes queued.
    tx_len_min = 10;
    tx_len_max = 10;
    bus_op(1'b1, 2'd0, 8'h61);
    bus_op(1'b1, 2'd0, 8'h62);
    bus_op(1'b1, 2'd0, 8'h63);
    idle_cycles(2);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    bus_op(1'b0, 2'd1, 8'h00);
    idle_cycles(12);
    bus_op(1'b0, 2'd1, 8'h00);

    // Randomized traffic.
    tx_len_min = 1;
    tx_len_max = 6;
    bus_op(1'b1, 2'd2, 8'h03);
    for (int i = 0; i < 400; i++) begin
      r = int'($urandom_range(9, 0));
      case (r)
        0, 1, 2: bus_op(1'b1, 2'd0, 8'($urandom));
        3, 4:    bus_op(1'b0, 2'($urandom_range(3, 0)), 8'h00);
        5:       bus_op(1'b1, 2'($urandom_range(3, 1)), 8'($urandom));
        6: begin
          if (rx_send_q.size() < 3) begin
            if ($urandom_range(7, 0) == 0) rx_send(1'($urandom), 1'b1, 8'($urandom),
                                                   int'($urandom_range(2, 0)));
            else rx_send(1'b1, 1'b0, 8'($urandom), int'($urandom_range(2, 0)));
          end
        end
        default: idle_cycles(int'($urandom_range(3, 1)));
      endcase
    end
    wait_rx_drained();
    idle_cycles(40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
